// File: rtl/snitch_icache_pkg.sv
// snitch_icache_pkg: cache configuration shared by the instruction-cache blocks.
package snitch_icache_pkg;
  typedef struct packed {
    int unsigned SET_COUNT;
    int unsigned LINE_COUNT;
    int unsigned COUNT_ALIGN;
    int unsigned TAG_WIDTH;
  } config_t;
  localparam config_t DefaultCfg = '{SET_COUNT: 4, LINE_COUNT: 128, COUNT_ALIGN: 7, TAG_WIDTH: 16};
endpackage

// File: rtl/lzc.sv
// lzc: trailing-zero count (index of the lowest set bit) with empty flag.
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned CNT_WIDTH = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) cnt_o = in_i[i] ? CNT_WIDTH'(i) : cnt_o;
  end
  assign empty_o = ~|in_i;
endmodule

// File: rtl/snitch_icache_tag_victim.sv
// snitch_icache_tag_victim: picks the lowest invalid way, else a round-robin way.
module snitch_icache_tag_victim import snitch_icache_pkg::*; #(
  parameter config_t     CFG  = DefaultCfg,
  parameter int unsigned SetW = CFG.SET_COUNT > 1 ? $clog2(CFG.SET_COUNT) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [CFG.SET_COUNT-1:0] valid_i,
  input  logic                     miss_hsk_i,
  output logic [SetW-1:0]          victim_o
);
  logic [SetW-1:0] rr_q, rr_d, inv_idx;
  logic all_valid;
  lzc #(.WIDTH(CFG.SET_COUNT)) i_inv (.in_i(~valid_i), .cnt_o(inv_idx), .empty_o(all_valid));
  assign victim_o = all_valid ? rr_q : inv_idx;
  // The pointer only moves when it was actually used to evict; wraps for non-power-of-2 sets.
  assign rr_d = (miss_hsk_i & all_valid)
              ? (rr_q == SetW'(CFG.SET_COUNT - 1) ? '0 : rr_q + SetW'(1)) : rr_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else rr_q <= rr_d;
  end
endmodule

// File: rtl/snitch_icache_tag_ctrl.sv
// snitch_icache_tag_ctrl: drives the tag SRAM for init/flush clears, lookups and refill writes,
// and turns the returned tags into hit/victim responses.
module snitch_icache_tag_ctrl import snitch_icache_pkg::*; #(
  parameter config_t     CFG  = DefaultCfg,
  parameter int unsigned SetW = CFG.SET_COUNT > 1 ? $clog2(CFG.SET_COUNT) : 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        flush_valid_i,
  output logic                                        flush_ready_o,
  input  logic                                        lookup_valid_i,
  output logic                                        lookup_ready_o,
  input  logic [CFG.COUNT_ALIGN-1:0]                  lookup_index_i,
  input  logic [CFG.TAG_WIDTH-1:0]                    lookup_tag_i,
  output logic                                        rsp_valid_o,
  input  logic                                        rsp_ready_i,
  output logic                                        rsp_hit_o,
  output logic                                        rsp_error_o,
  output logic [SetW-1:0]                             rsp_set_o,
  input  logic                                        write_valid_i,
  output logic                                        write_ready_o,
  input  logic [CFG.COUNT_ALIGN-1:0]                  write_index_i,
  input  logic [SetW-1:0]                             write_set_i,
  input  logic [CFG.TAG_WIDTH-1:0]                    write_tag_i,
  input  logic                                        write_error_i,
  output logic [CFG.SET_COUNT-1:0]                    ram_enable_o,
  output logic                                        ram_write_o,
  output logic [CFG.COUNT_ALIGN-1:0]                  ram_addr_o,
  output logic [CFG.SET_COUNT*(CFG.TAG_WIDTH+2)-1:0]  ram_wtag_o,
  input  logic [CFG.SET_COUNT*(CFG.TAG_WIDTH+2)-1:0]  ram_rtag_i
);
  localparam int unsigned SC        = CFG.SET_COUNT;
  localparam int unsigned CA        = CFG.COUNT_ALIGN;
  localparam int unsigned TW        = CFG.TAG_WIDTH;
  localparam int unsigned EW        = TW + 2;
  localparam int unsigned VALID_BIT = TW + 1;
  localparam int unsigned ERROR_BIT = TW;
  typedef enum logic [1:0] {INIT, IDLE, FLUSH} state_e;
  state_e state_q, state_d;
  logic [CA-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tag_q;
  logic rsp_valid_q, rsp_valid_d;
  logic idle, slot_free, last, do_flush, do_write, do_lookup, no_hit;
  logic [SC-1:0] way_valid, way_err, way_hit;
  logic [SetW-1:0] hit_idx, victim;
  for (genvar i = 0; i < SC; i++) begin : g_way
    assign way_valid[i] = ram_rtag_i[i*EW+VALID_BIT];
    assign way_err[i]   = ram_rtag_i[i*EW+ERROR_BIT];
    assign way_hit[i]   = way_valid[i] & (ram_rtag_i[i*EW +: TW] == tag_q);
  end
  lzc #(.WIDTH(SC)) i_hit (.in_i(way_hit), .cnt_o(hit_idx), .empty_o(no_hit));
  snitch_icache_tag_victim #(.CFG(CFG)) i_victim (
    .clk_i, .rst_ni,
    .valid_i    (way_valid),
    .miss_hsk_i (rsp_valid_q & rsp_ready_i & no_hit),
    .victim_o   (victim)
  );
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_hit_o   = ~no_hit;
  assign rsp_error_o = ~no_hit & way_err[hit_idx];
  assign rsp_set_o   = no_hit ? victim : hit_idx;
  // A stalled response blocks new SRAM reads so the read data it depends on stays put.
  assign idle           = state_q == IDLE;
  assign slot_free      = ~rsp_valid_q | rsp_ready_i;
  assign last           = cnt_q == CA'(CFG.LINE_COUNT - 1);
  assign write_ready_o  = idle & slot_free & ~flush_valid_i;
  assign lookup_ready_o = write_ready_o & ~write_valid_i;
  assign do_flush       = idle & slot_free & flush_valid_i;
  assign do_write       = write_ready_o & write_valid_i;
  assign do_lookup      = lookup_ready_o & lookup_valid_i;
  assign rsp_valid_d    = do_lookup | (rsp_valid_q & ~rsp_ready_i);
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    flush_ready_o = 1'b0;
    ram_enable_o  = '0;
    ram_write_o   = 1'b0;
    ram_addr_o    = cnt_q;
    ram_wtag_o    = '0;
    if (!idle || do_flush) begin
      ram_enable_o  = '1;
      ram_write_o   = 1'b1;
      cnt_d         = last ? '0 : cnt_q + CA'(1);
      state_d       = last ? IDLE : (idle ? FLUSH : state_q);
      flush_ready_o = last & (state_q != INIT);
    end else if (do_write) begin
      ram_enable_o = SC'(1) << write_set_i;
      ram_write_o  = 1'b1;
      ram_addr_o   = write_index_i;
      ram_wtag_o   = {SC{1'b1, write_error_i, write_tag_i}};
    end else if (do_lookup) begin
      ram_enable_o = '1;
      ram_addr_o   = lookup_index_i;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      tag_q       <= do_lookup ? lookup_tag_i : tag_q;
    end
  end
endmodule

// File: tb/tb_snitch_icache_tag_ctrl.sv
// tb_snitch_icache_tag_ctrl: vector table, corner sequences and random traffic against a way-array model.
module tb_snitch_icache_tag_ctrl;
  import snitch_icache_pkg::*;
  localparam config_t Cfg = '{SET_COUNT: 4, LINE_COUNT: 128, COUNT_ALIGN: 7, TAG_WIDTH: 16};
  logic clk = 1'b0, rst_n = 1'b0;
  logic flush_valid_i = 0, flush_ready_o, lookup_valid_i = 0, lookup_ready_o;
  logic [6:0] lookup_index_i = '0, write_index_i = '0, ram_addr_o;
  logic [15:0] lookup_tag_i = '0, write_tag_i = '0;
  logic rsp_valid_o, rsp_ready_i = 1'b1, rsp_hit_o, rsp_error_o;
  logic [1:0] rsp_set_o, write_set_i = '0;
  logic write_valid_i = 0, write_ready_o, write_error_i = 0;
  logic [3:0] ram_enable_o;
  logic ram_write_o;
  logic [71:0] ram_wtag_o, ram_rtag_i;
  logic [17:0] mem [128][4];
  logic [17:0] rdata [4];
  int pass_cnt = 0, chk_cnt = 0;
  // Reference: plain per-line way arrays plus a modulo-4 eviction pointer.
  bit mv [128][4];
  bit me [128][4];
  logic [15:0] mt [128][4];
  int rr = 0;

  snitch_icache_tag_ctrl #(.CFG(Cfg)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .lookup_index_i(lookup_index_i), .lookup_tag_i(lookup_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_hit_o(rsp_hit_o), .rsp_error_o(rsp_error_o), .rsp_set_o(rsp_set_o),
    .write_valid_i(write_valid_i), .write_ready_o(write_ready_o),
    .write_index_i(write_index_i), .write_set_i(write_set_i),
    .write_tag_i(write_tag_i), .write_error_i(write_error_i),
    .ram_enable_o(ram_enable_o), .ram_write_o(ram_write_o), .ram_addr_o(ram_addr_o),
    .ram_wtag_o(ram_wtag_o), .ram_rtag_i(ram_rtag_i)
  );

  always #5 clk = ~clk;

  // Tag SRAM: garbage while in reset so the clearing pass is observable.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int a = 0; a < 128; a++)
        for (int s = 0; s < 4; s++) mem[a][s] <= 18'($urandom) | 18'h20000;
    end else begin
      for (int s = 0; s < 4; s++)
        if (ram_enable_o[s]) begin
          if (ram_write_o) mem[ram_addr_o][s] <= ram_wtag_o[s*18 +: 18];
          else rdata[s] <= mem[ram_addr_o][s];
        end
    end
  end
  assign ram_rtag_i = {rdata[3], rdata[2], rdata[1], rdata[0]};

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int a = 0; a < 128; a++)
      for (int w = 0; w < 4; w++) mv[a][w] = 0;
  endtask

  task automatic model_lk(input int idx, input logic [15:0] tag,
                          output logic h, output logic [1:0] s, output logic e);
    int inv;
    h = 0; s = 0; e = 0; inv = -1;
    for (int w = 3; w >= 0; w--)
      if (mv[idx][w] && mt[idx][w] == tag) begin h = 1; s = 2'(w); e = me[idx][w]; end
    if (!h) begin
      for (int w = 3; w >= 0; w--) if (!mv[idx][w]) inv = w;
      if (inv >= 0) s = 2'(inv);
      else begin s = 2'(rr); rr = (rr + 1) % 4; end
    end
  endtask

  task automatic wr(input logic [6:0] idx, input logic [1:0] set, input logic [15:0] tag, input logic err);
    lookup_valid_i = 0; write_valid_i = 1;
    write_index_i = idx; write_set_i = set; write_tag_i = tag; write_error_i = err;
    #1 chk("wr_ready", write_ready_o, 1);
    chk("wr_cmd", {ram_enable_o, ram_write_o, ram_addr_o}, {4'b1 << set, 1'b1, idx});
    chk("wr_wtag", ram_wtag_o, {4{1'b1, err, tag}});
    nxt();
    write_valid_i = 0;
    mv[idx][set] = 1; me[idx][set] = err; mt[idx][set] = tag;
  endtask

  task automatic lk(input logic [6:0] idx, input logic [15:0] tag, input int stall,
                    output logic h, output logic [1:0] s, output logic e);
    int ok;
    write_valid_i = 0; lookup_valid_i = 1; rsp_ready_i = 1;
    lookup_index_i = idx; lookup_tag_i = tag;
    #1 chk("lk_ready", lookup_ready_o, 1);
    chk("lk_cmd", {ram_enable_o, ram_write_o, ram_addr_o}, {4'hF, 1'b0, idx});
    nxt();
    lookup_valid_i = 0; rsp_ready_i = (stall == 0);
    #1 chk("rsp_valid", rsp_valid_o, 1);
    h = rsp_hit_o; s = rsp_set_o; e = rsp_error_o;
    if (stall > 0) begin
      ok = 0;
      for (int k = 0; k < stall; k++) begin
        nxt();
        #1 if (rsp_valid_o && rsp_hit_o == h && rsp_set_o == s && rsp_error_o == e &&
               !lookup_ready_o && !write_ready_o && ram_enable_o == 4'h0) ok++;
      end
      chk("stall_hold", ok, stall);
      rsp_ready_i = 1;
    end
  endtask

  task automatic lk_model(input logic [6:0] idx, input logic [15:0] tag, input int stall, input string nm);
    logic h, e, mh, me_;
    logic [1:0] s, ms;
    lk(idx, tag, stall, h, s, e);
    model_lk(idx, tag, mh, ms, me_);
    chk({nm, "_rsp"}, {h, s, e}, {mh, ms, me_});
  endtask

  typedef struct {
    bit wr; logic [6:0] idx; logic [1:0] set; logic [15:0] tag; logic err;
    logic eh; logic [1:0] es; logic ee;
  } vec_t;
  vec_t tbl[$];

  initial begin
    logic h, e, h2, e2, mh, me_;
    logic [1:0] s, s2, ms;
    int good, c;
    tbl.push_back('{0, 7'd5, 2'd0, 16'h1234, 0, 0, 2'd0, 0});
    tbl.push_back('{1, 7'd5, 2'd2, 16'h0ABC, 1, 0, 2'd0, 0});
    tbl.push_back('{0, 7'd5, 2'd0, 16'h0ABC, 0, 1, 2'd2, 1});
    for (int w = 0; w < 4; w++) tbl.push_back('{1, 7'd7, 2'(w), 16'(16'h100 + w), 0, 0, 2'd0, 0});
    for (int m = 0; m < 5; m++) tbl.push_back('{0, 7'd7, 2'd0, 16'(16'h200 + m), 0, 0, 2'(m % 4), 0});
    tbl.push_back('{0, 7'd7, 2'd0, 16'h0102, 0, 1, 2'd2, 0});
    tbl.push_back('{1, 7'd8, 2'd3, 16'h0077, 1, 0, 2'd0, 0});
    tbl.push_back('{1, 7'd8, 2'd1, 16'h0077, 0, 0, 2'd0, 0});
    tbl.push_back('{0, 7'd8, 2'd0, 16'h0077, 0, 1, 2'd1, 0});

    model_clear();
    nxt(); nxt();
    #1 chk("rst_ready", {flush_ready_o, lookup_ready_o, write_ready_o, rsp_valid_o}, 4'b0);
    chk("rst_ram", {ram_enable_o, ram_write_o, ram_addr_o}, {4'hF, 1'b1, 7'd0});
    chk("rst_wtag", ram_wtag_o, 72'd0);
    rst_n = 1;
    good = 0;
    for (int i = 0; i < 128; i++) begin
      #1 if (ram_enable_o == 4'hF && ram_write_o && ram_addr_o == 7'(i) && ram_wtag_o == 72'd0 &&
             !lookup_ready_o && !write_ready_o) good++;
      nxt();
    end
    chk("init_seq", good, 128);
    #1 chk("init_done_ready", lookup_ready_o, 1);

    foreach (tbl[i]) begin
      if (tbl[i].wr) wr(tbl[i].idx, tbl[i].set, tbl[i].tag, tbl[i].err);
      else begin
        lk(tbl[i].idx, tbl[i].tag, 0, h, s, e);
        model_lk(tbl[i].idx, tbl[i].tag, mh, ms, me_);
        chk($sformatf("vec%0d", i), {h, s, e}, {tbl[i].eh, tbl[i].es, tbl[i].ee});
      end
    end

    lk(7'd5, 16'h0ABC, 3, h, s, e);
    model_lk(7'd5, 16'h0ABC, mh, ms, me_);
    chk("stall_rsp", {h, s, e}, {1'b1, 2'd2, 1'b1});

    // Concurrent write and lookup: write goes first, lookup follows and sees it.
    write_valid_i = 1; write_index_i = 7'd9; write_set_i = 2'd1; write_tag_i = 16'h55; write_error_i = 0;
    lookup_valid_i = 1; lookup_index_i = 7'd9; lookup_tag_i = 16'h55;
    #1 chk("both_ready", {write_ready_o, lookup_ready_o, ram_write_o}, 3'b101);
    nxt();
    write_valid_i = 0;
    mv[9][1] = 1; me[9][1] = 0; mt[9][1] = 16'h55;
    #1 chk("both_lk_next", {lookup_ready_o, ram_write_o, rsp_valid_o}, 3'b100);
    nxt();
    lookup_valid_i = 0;
    #1 chk("both_rsp", {rsp_valid_o, rsp_hit_o, rsp_set_o}, {1'b1, 1'b1, 2'd1});
    model_lk(7'd9, 16'h55, mh, ms, me_);

    // Back-to-back lookups: one accepted per cycle.
    lookup_valid_i = 1; lookup_index_i = 7'd7; lookup_tag_i = 16'h0101;
    #1 chk("b2b_ready0", lookup_ready_o, 1);
    nxt();
    lookup_index_i = 7'd8; lookup_tag_i = 16'h0077;
    #1 chk("b2b_ready1", {lookup_ready_o, rsp_valid_o}, 2'b11);
    h = rsp_hit_o; s = rsp_set_o; e = rsp_error_o;
    model_lk(7'd7, 16'h0101, mh, ms, me_);
    chk("b2b_rsp0", {h, s, e}, {mh, ms, me_});
    nxt();
    lookup_valid_i = 0;
    #1 chk("b2b_valid1", rsp_valid_o, 1);
    h2 = rsp_hit_o; s2 = rsp_set_o; e2 = rsp_error_o;
    model_lk(7'd8, 16'h0077, mh, ms, me_);
    chk("b2b_rsp1", {h2, s2, e2}, {mh, ms, me_});

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 4)
        wr(7'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom_range(0, 5)), 1'($urandom));
      else
        lk_model(7'($urandom_range(0, 3)), 16'($urandom_range(0, 5)), $urandom_range(0, 2), "rand");
    end

    nxt();
    flush_valid_i = 1;
    #1 chk("flush_accept", {write_ready_o, ram_write_o, ram_addr_o, ram_enable_o, flush_ready_o},
           {1'b0, 1'b1, 7'd0, 4'hF, 1'b0});
    c = 0;
    while (!flush_ready_o && c < 400) begin
      nxt();
      #1 c++;
    end
    chk("flush_latency", c, 127);
    nxt();
    flush_valid_i = 0;
    model_clear();
    lk(7'd5, 16'h0ABC, 0, h, s, e);
    chk("post_flush_rsp", {h, s, e}, {1'b0, 2'd0, 1'b0});
    model_lk(7'd5, 16'h0ABC, mh, ms, me_);
    nxt();

    // Reset mid-INIT restarts clearing; a flush raised during INIT runs after it.
    rst_n = 0;
    nxt(); nxt();
    rst_n = 1;
    for (int i = 0; i < 50; i++) nxt();
    rst_n = 0;
    #1 chk("reinit_rst", {ram_addr_o, ram_write_o, rsp_valid_o, lookup_ready_o}, {7'd0, 1'b1, 1'b0, 1'b0});
    nxt();
    rst_n = 1; flush_valid_i = 1;
    c = 0;
    #1 while (!flush_ready_o && c < 400) begin
      nxt();
      #1 c++;
    end
    chk("init_flush_latency", c, 255);
    nxt();
    flush_valid_i = 0;
    model_clear(); rr = 0;
    lk_model(7'd7, 16'h0101, 0, "after_reinit");
    nxt();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
